// File: rtl/clk_domain_gen.sv
// ---------------------------------------------------------------------------
// clk_domain_gen
//
// Multi-channel programmable clock divider. It replaces the old fixed
// divide-by-4 divider that produced the processor and regfile clocks. The
// single master clock drives NUM_CH independent channels. Each channel has its
// own divide ratio and phase offset, and both can be changed at runtime.
//
// Each channel counts 0 .. div-1. The registered output div_clk[i] is high
// while the counter sits in the upper floor(div/2) states, so odd ratios
// spend the extra cycle low. A new ratio/phase is held as pending and is only
// taken on the channel's own wrap edge. This keeps the output free of
// runt pulses.
//
// Optional feature (macro CLKDIV_RESYNC_EN):
//   Adds input `resync`. A one-cycle pulse realigns every channel to its
//   phase on the next edge, applies pending configs and pulses tick.
//
// Ports:
//   clock      in   master clock, rising edge
//   reset      in   synchronous, active-high reset
//   run        in   1 = count, 0 = halt each channel at its next wrap
//   resync     in   (CLKDIV_RESYNC_EN only) realign all channels to phase
//   cfg_wr     in   strobe: request new div/phase for channel cfg_ch
//   cfg_ch     in   [CH_W]   target channel
//   cfg_div    in   [DIV_W]  requested divide ratio (>= 2)
//   cfg_phase  in   [DIV_W]  requested start count (< cfg_div)
//   cfg_ack    out  one-cycle pulse: at least one pending config applied
//   cfg_err    out  one-cycle pulse: previous cfg_wr rejected
//   div_clk    out  [NUM_CH] registered divided clocks
//   tick       out  [NUM_CH] one-cycle pulse at each period boundary
//   stopped    out  high while every channel is halted
// ---------------------------------------------------------------------------
module clk_domain_gen #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int CH_W        = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
`ifdef CLKDIV_RESYNC_EN
  input  logic              resync,
`endif
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick,
  output logic              stopped
);

  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO     = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  // Active per-channel state
  logic [DIV_W-1:0] cnt_q    [NUM_CH];
  logic [DIV_W-1:0] div_q    [NUM_CH];
  logic [DIV_W-1:0] phase_q  [NUM_CH];
  logic [DIV_W-1:0] pdiv_q   [NUM_CH];
  logic [DIV_W-1:0] pphase_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] halted_q;

  // Next-state values
  logic [DIV_W-1:0] cnt_d    [NUM_CH];
  logic [DIV_W-1:0] div_d    [NUM_CH];
  logic [DIV_W-1:0] phase_d  [NUM_CH];
  logic [DIV_W-1:0] pdiv_d   [NUM_CH];
  logic [DIV_W-1:0] pphase_d [NUM_CH];
  logic [NUM_CH-1:0] pend_d;
  logic [NUM_CH-1:0] halted_d;
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] tick_d;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] wrap;

  logic cfg_ok;
  logic resync_now;

  // The output is high once the count passes the low half. The low half is
  // ceil(div/2) long, so odd ratios are biased low.
  function automatic logic high_phase(input logic [DIV_W-1:0] c,
                                      input logic [DIV_W-1:0] d);
    return c >= (d - (d >> 1));
  endfunction

`ifdef CLKDIV_RESYNC_EN
  assign resync_now = resync;
`else
  assign resync_now = 1'b0;
`endif

  // A request is legal only if the ratio gives at least two states, the
  // phase lies inside the period and the channel exists.
  always_comb begin
    cfg_ok = (cfg_div >= TWO) && (cfg_phase < cfg_div) &&
             (int'(cfg_ch) < NUM_CH);
  end

  // A wrap is the last count of a running channel's period.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wrap[i] = !halted_q[i] && (cnt_q[i] == (div_q[i] - ONE));
    end
  end

  // Per-channel next state. A pending config is taken on a wrap, on any edge
  // while halted, or on resync. The new div/phase then feed the output
  // computed on that same edge. A write arriving on the same edge only
  // refreshes the pending slot, so it waits for the following wrap.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i]    = cnt_q[i];
      div_d[i]    = div_q[i];
      phase_d[i]  = phase_q[i];
      pdiv_d[i]   = pdiv_q[i];
      pphase_d[i] = pphase_q[i];
      pend_d[i]   = pend_q[i];
      halted_d[i] = halted_q[i];
      clk_d[i]    = 1'b0;
      tick_d[i]   = 1'b0;

      apply[i] = pend_q[i] && (resync_now || halted_q[i] || wrap[i]);
      if (apply[i]) begin
        div_d[i]   = pdiv_q[i];
        phase_d[i] = pphase_q[i];
        pend_d[i]  = 1'b0;
      end

      if (resync_now) begin
        // A channel that is halted and still told to stop stays parked at
        // zero. Every other channel restarts from its phase.
        tick_d[i] = 1'b1;
        if (halted_q[i] && !run) begin
          cnt_d[i] = '0;
        end else begin
          halted_d[i] = 1'b0;
          cnt_d[i]    = phase_d[i];
          clk_d[i]    = high_phase(phase_d[i], div_d[i]);
        end
      end else if (halted_q[i]) begin
        if (run) begin
          halted_d[i] = 1'b0;
          cnt_d[i]    = phase_d[i];
          clk_d[i]    = high_phase(phase_d[i], div_d[i]);
        end
      end else if (wrap[i]) begin
        if (!run) begin
          halted_d[i] = 1'b1;
          cnt_d[i]    = '0;
          tick_d[i]   = 1'b1;
        end else begin
          cnt_d[i]  = apply[i] ? phase_d[i] : '0;
          clk_d[i]  = high_phase(cnt_d[i], div_d[i]);
          tick_d[i] = (cnt_d[i] == '0);
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
        clk_d[i] = high_phase(cnt_d[i], div_q[i]);
      end

      if (cfg_wr && cfg_ok && (cfg_ch == CH_W'(i))) begin
        pend_d[i]   = 1'b1;
        pdiv_d[i]   = cfg_div;
        pphase_d[i] = cfg_phase;
      end
    end
  end

  // Reset discards any pending configuration and returns every channel to
  // the default ratio with no ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= '0;
        div_q[i]    <= DIV_RST;
        phase_q[i]  <= '0;
        pdiv_q[i]   <= DIV_RST;
        pphase_q[i] <= '0;
      end
      pend_q   <= '0;
      halted_q <= '0;
      div_clk  <= '0;
      tick     <= '0;
      cfg_ack  <= 1'b0;
      cfg_err  <= 1'b0;
      stopped  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]    <= cnt_d[i];
        div_q[i]    <= div_d[i];
        phase_q[i]  <= phase_d[i];
        pdiv_q[i]   <= pdiv_d[i];
        pphase_q[i] <= pphase_d[i];
      end
      pend_q   <= pend_d;
      halted_q <= halted_d;
      div_clk  <= clk_d;
      tick     <= tick_d;
      cfg_ack  <= |apply;
      cfg_err  <= cfg_wr && !cfg_ok;
      stopped  <= &halted_d;
    end
  end

endmodule
